// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - state encoding, opcodes and IR field positions for the sequencer
package seq_pkg;

  localparam logic [3:0] ST_IDLE = 4'd0;
  localparam logic [3:0] ST_T0   = 4'd1;
  localparam logic [3:0] ST_T1   = 4'd2;
  localparam logic [3:0] ST_T2   = 4'd3;
  localparam logic [3:0] ST_T3   = 4'd4;
  localparam logic [3:0] ST_T4   = 4'd5;
  localparam logic [3:0] ST_T5   = 4'd6;
  localparam logic [3:0] ST_T6   = 4'd7;
  localparam logic [3:0] ST_HALT = 4'd8;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHL  = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_AND  = 5'b01001;
  localparam logic [4:0] OP_OR   = 5'b01010;
  localparam logic [4:0] OP_MUL  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_NEG  = 5'b10000;
  localparam logic [4:0] OP_NOT  = 5'b10001;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam int OP_MSB = 31;
  localparam int OP_LSB = 27;
  localparam int RA_MSB = 26;
  localparam int RA_LSB = 23;
  localparam int RB_MSB = 22;
  localparam int RB_LSB = 19;
  localparam int RC_MSB = 18;
  localparam int RC_LSB = 15;

  // Two-source ops read Rb into RY, then Rc onto the bus in T4.
  function automatic logic is_binary_op(input logic [4:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_SHR, OP_SHL, OP_ROR, OP_ROL,
      OP_AND, OP_OR, OP_MUL, OP_DIV: return 1'b1;
      default:                       return 1'b0;
    endcase
  endfunction

  // Single-source ops skip the RY load and drive Rb in T4.
  function automatic logic is_unary_op(input logic [4:0] op);
    return (op == OP_NEG) || (op == OP_NOT);
  endfunction

endpackage

// File: rtl/reg_onehot_decoder.sv
// rtl/reg_onehot_decoder.sv - register index to one-hot select with enable
module reg_onehot_decoder
  import seq_pkg::*;
#(
  parameter int RIDX      = 4,
  parameter int REGISTERS = 16
) (
  input  logic [RIDX-1:0]      idx_i,
  input  logic                 en_i,
  output logic [REGISTERS-1:0] onehot_o
);

  // Indices at or beyond REGISTERS match no bit, leaving the vector all-zero.
  always_comb begin
    onehot_o = '0;
    for (int i = 0; i < REGISTERS; i++) begin
      if (en_i && (idx_i == RIDX'(i))) begin
        onehot_o[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/datapath_sequencer.sv
// rtl/datapath_sequencer.sv - Moore fetch/execute control FSM for the single-bus datapath
module datapath_sequencer
  import seq_pkg::*;
#(
  parameter int BITS      = 32,
  parameter int REGISTERS = 16,
  parameter int RIDX      = 4
) (
  input  logic                 Clock,
  input  logic                 reset,
  input  logic                 run,
  input  logic                 mem_wait,
  input  logic [BITS-1:0]      IRVal,
  output logic                 PCout,
  output logic                 MDRout,
  output logic                 Zlowout,
  output logic                 Zhighout,
  output logic                 LOout,
  output logic                 HIout,
  output logic                 PCin,
  output logic                 IRin,
  output logic                 RYin,
  output logic                 RZin,
  output logic                 MARin,
  output logic                 MDRin,
  output logic                 HIin,
  output logic                 LOin,
  output logic                 Read,
  output logic                 IncPC,
  output logic                 ADD,
  output logic                 SUB,
  output logic                 MUL,
  output logic                 DIV,
  output logic                 SHR,
  output logic                 SHL,
  output logic                 ROR,
  output logic                 ROL,
  output logic                 AND,
  output logic                 OR,
  output logic                 NEGATE,
  output logic                 NOT,
  output logic [REGISTERS-1:0] GPRin,
  output logic [REGISTERS-1:0] GPRout,
  output logic                 instr_done,
  output logic                 halted,
  output logic                 illegal
);

  logic [3:0]      state_q, state_d;
  logic            illegal_q;
  logic [4:0]      op;
  logic [RIDX-1:0] ra, rb, rc;
  logic            bin_op, una_op, halt_op, legal_op, muldiv_op;
  logic [RIDX-1:0] gpr_out_idx;
  logic            gpr_out_en, gpr_in_en;
  logic            unused_ir_low;

  assign op        = IRVal[OP_MSB:OP_LSB];
  assign ra        = IRVal[RA_MSB:RA_LSB];
  assign rb        = IRVal[RB_MSB:RB_LSB];
  assign rc        = IRVal[RC_MSB:RC_LSB];
  assign bin_op    = is_binary_op(op);
  assign una_op    = is_unary_op(op);
  assign halt_op   = (op == OP_HALT);
  assign legal_op  = bin_op || una_op || halt_op;
  assign muldiv_op = (op == OP_MUL) || (op == OP_DIV);
  assign unused_ir_low = ^IRVal[RC_LSB-1:0];

  // State and sticky illegal flag; reset overrides run and mem_wait.
  always_ff @(posedge Clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if ((state_q == ST_T3) && !legal_op) begin
        illegal_q <= 1'b1;
      end
    end
  end

  // Next-state sequencing through fetch and execute steps.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (run) state_d = ST_T0;
      ST_T0:   state_d = ST_T1;
      ST_T1:   if (!mem_wait) state_d = ST_T2;
      ST_T2:   state_d = ST_T3;
      ST_T3:   state_d = legal_op && !halt_op ? ST_T4 : ST_HALT;
      ST_T4:   state_d = ST_T5;
      ST_T5:   state_d = muldiv_op ? ST_T6 : ST_T0;
      ST_T6:   state_d = ST_T0;
      ST_HALT: if (run) state_d = ST_T0;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath strobes decoded from the current state and IR contents only.
  always_comb begin
    {PCout, MDRout, Zlowout, Zhighout, LOout, HIout} = '0;
    {PCin, IRin, RYin, RZin, MARin, MDRin, HIin, LOin} = '0;
    {Read, IncPC, instr_done} = '0;
    {ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, AND, OR, NEGATE, NOT} = '0;
    case (state_q)
      ST_T0: {PCout, MARin, IncPC, RZin} = '1;
      ST_T1: {Zlowout, PCin, Read, MDRin} = '1;
      ST_T2: {MDRout, IRin} = '1;
      ST_T3: RYin = bin_op;
      ST_T4: begin
        RZin = bin_op || una_op;
        case (op)
          OP_ADD: ADD    = 1'b1;
          OP_SUB: SUB    = 1'b1;
          OP_MUL: MUL    = 1'b1;
          OP_DIV: DIV    = 1'b1;
          OP_SHR: SHR    = 1'b1;
          OP_SHL: SHL    = 1'b1;
          OP_ROR: ROR    = 1'b1;
          OP_ROL: ROL    = 1'b1;
          OP_AND: AND    = 1'b1;
          OP_OR:  OR     = 1'b1;
          OP_NEG: NEGATE = 1'b1;
          OP_NOT: NOT    = 1'b1;
          default: ;
        endcase
      end
      ST_T5: begin
        Zlowout    = 1'b1;
        LOin       = muldiv_op;
        instr_done = !muldiv_op;
      end
      ST_T6: {Zhighout, HIin, instr_done} = '1;
      default: ;
    endcase
  end

  // T3 drives Rb for binary ops; T4 drives Rc (binary) or Rb (unary).
  assign gpr_out_idx = ((state_q == ST_T4) && bin_op) ? rc : rb;
  assign gpr_out_en  = ((state_q == ST_T3) && bin_op) ||
                       ((state_q == ST_T4) && (bin_op || una_op));
  assign gpr_in_en   = (state_q == ST_T5) && !muldiv_op && (bin_op || una_op);

  assign halted  = (state_q == ST_HALT);
  assign illegal = illegal_q;

  reg_onehot_decoder #(.RIDX(RIDX), .REGISTERS(REGISTERS)) u_gpr_out_dec (
    .idx_i    (gpr_out_idx),
    .en_i     (gpr_out_en),
    .onehot_o (GPRout)
  );

  reg_onehot_decoder #(.RIDX(RIDX), .REGISTERS(REGISTERS)) u_gpr_in_dec (
    .idx_i    (ra),
    .en_i     (gpr_in_en),
    .onehot_o (GPRin)
  );

endmodule

// File: tb/tb_datapath_sequencer.sv
// tb/tb_datapath_sequencer.sv - directed scoreboard bench for datapath_sequencer
module tb_datapath_sequencer;

  logic        Clock = 1'b0;
  logic        reset, run, mem_wait;
  logic [31:0] IRVal;
  logic PCout, MDRout, Zlowout, Zhighout, LOout, HIout;
  logic PCin, IRin, RYin, RZin, MARin, MDRin, HIin, LOin;
  logic Read, IncPC;
  logic ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, AND, OR, NEGATE, NOT;
  logic [15:0] GPRin, GPRout;
  logic instr_done, halted, illegal;

  always #5 Clock = ~Clock;

  datapath_sequencer #(.BITS(32), .REGISTERS(16), .RIDX(4)) dut (
    .Clock(Clock), .reset(reset), .run(run), .mem_wait(mem_wait), .IRVal(IRVal),
    .PCout(PCout), .MDRout(MDRout), .Zlowout(Zlowout), .Zhighout(Zhighout),
    .LOout(LOout), .HIout(HIout), .PCin(PCin), .IRin(IRin), .RYin(RYin),
    .RZin(RZin), .MARin(MARin), .MDRin(MDRin), .HIin(HIin), .LOin(LOin),
    .Read(Read), .IncPC(IncPC), .ADD(ADD), .SUB(SUB), .MUL(MUL), .DIV(DIV),
    .SHR(SHR), .SHL(SHL), .ROR(ROR), .ROL(ROL), .AND(AND), .OR(OR),
    .NEGATE(NEGATE), .NOT(NOT), .GPRin(GPRin), .GPRout(GPRout),
    .instr_done(instr_done), .halted(halted), .illegal(illegal)
  );

  typedef struct packed {
    logic PCout, MDRout, Zlowout, Zhighout, LOout, HIout;
    logic PCin, IRin, RYin, RZin, MARin, MDRin, HIin, LOin;
    logic Read, IncPC;
    logic [11:0] alu;
    logic [15:0] gprin, gprout;
    logic instr_done, halted, illegal;
  } obs_t;

  localparam int A_ADD = 11, A_SUB = 10, A_MUL = 9, A_DIV = 8, A_SHR = 7, A_SHL = 6;
  localparam int A_ROR = 5, A_ROL = 4, A_AND = 3, A_OR = 2, A_NEG = 1, A_NOT = 0;

  obs_t obs;
  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  assign obs = {PCout, MDRout, Zlowout, Zhighout, LOout, HIout,
                PCin, IRin, RYin, RZin, MARin, MDRin, HIin, LOin,
                Read, IncPC,
                {ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, AND, OR, NEGATE, NOT},
                GPRin, GPRout, instr_done, halted, illegal};

  function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [3:0] ra,
                                        input logic [3:0] rb, input logic [3:0] rc);
    return {op, ra, rb, rc, 15'd0};
  endfunction

  function automatic obs_t e_idle(input logic ill);
    obs_t o = '0;
    o.illegal = ill;
    return o;
  endfunction

  function automatic obs_t e_t0(input logic ill);
    obs_t o = e_idle(ill);
    o.PCout = 1'b1; o.MARin = 1'b1; o.IncPC = 1'b1; o.RZin = 1'b1;
    return o;
  endfunction

  function automatic obs_t e_t1(input logic ill);
    obs_t o = e_idle(ill);
    o.Zlowout = 1'b1; o.PCin = 1'b1; o.Read = 1'b1; o.MDRin = 1'b1;
    return o;
  endfunction

  function automatic obs_t e_t2(input logic ill);
    obs_t o = e_idle(ill);
    o.MDRout = 1'b1; o.IRin = 1'b1;
    return o;
  endfunction

  function automatic obs_t e_t3(input int rb, input logic ill);
    obs_t o = e_idle(ill);
    o.gprout = 16'(1) << rb; o.RYin = 1'b1;
    return o;
  endfunction

  function automatic obs_t e_t4(input int alu_bit, input int idx, input logic ill);
    obs_t o = e_idle(ill);
    o.gprout = 16'(1) << idx; o.alu[alu_bit] = 1'b1; o.RZin = 1'b1;
    return o;
  endfunction

  function automatic obs_t e_t5wb(input int ra, input logic ill);
    obs_t o = e_idle(ill);
    o.Zlowout = 1'b1; o.gprin = 16'(1) << ra; o.instr_done = 1'b1;
    return o;
  endfunction

  function automatic obs_t e_t5lo(input logic ill);
    obs_t o = e_idle(ill);
    o.Zlowout = 1'b1; o.LOin = 1'b1;
    return o;
  endfunction

  function automatic obs_t e_t6(input logic ill);
    obs_t o = e_idle(ill);
    o.Zhighout = 1'b1; o.HIin = 1'b1; o.instr_done = 1'b1;
    return o;
  endfunction

  function automatic obs_t e_halt(input logic ill);
    obs_t o = e_idle(ill);
    o.halted = 1'b1;
    return o;
  endfunction

  task automatic cyc(input logic r, input logic rn, input logic mw, input obs_t e,
                     input string tag);
    obs_t x;
    reset = r; run = rn; mem_wait = mw;
    exp_q.push_back(e);
    @(negedge Clock);
    x = exp_q.pop_front();
    checks++;
    assert (obs === x) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, x);
    end
    checks++;
    assert ($countones({PCout, MDRout, Zlowout, Zhighout, LOout, HIout, GPRout}) <= 1) else begin
      errors++;
      $error("FAIL %s_bus: observed %0d drivers expected <=1", tag,
             $countones({PCout, MDRout, Zlowout, Zhighout, LOout, HIout, GPRout}));
    end
    checks++;
    assert ($countones(obs.alu) <= 1) else begin
      errors++;
      $error("FAIL %s_alu: observed %h expected one-hot or zero", tag, obs.alu);
    end
    checks++;
    assert ($onehot0(GPRin) && $onehot0(GPRout)) else begin
      errors++;
      $error("FAIL %s_gpr: observed in %h out %h expected one-hot or zero", tag, GPRin, GPRout);
    end
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; mem_wait = 1'b0;
    IRVal = mk_ir(5'b00011, 4'd3, 4'd1, 4'd2);

    cyc(1, 0, 0, e_idle(0), "reset");
    cyc(1, 1, 0, e_idle(0), "reset_beats_run");
    cyc(0, 0, 0, e_idle(0), "idle_hold");

    // ADD R3 = R1 + R2
    cyc(0, 1, 0, e_t0(0), "add_t0");
    cyc(0, 0, 0, e_t1(0), "add_t1");
    cyc(0, 0, 0, e_t2(0), "add_t2");
    cyc(0, 0, 0, e_t3(1, 0), "add_t3");
    cyc(0, 0, 0, e_t4(A_ADD, 2, 0), "add_t4");
    cyc(0, 0, 0, e_t5wb(3, 0), "add_t5");
    cyc(0, 0, 0, e_t0(0), "add_back_t0");

    // MUL R0 = R4 * R5
    IRVal = mk_ir(5'b01110, 4'd0, 4'd4, 4'd5);
    cyc(0, 0, 0, e_t1(0), "mul_t1");
    cyc(0, 0, 0, e_t2(0), "mul_t2");
    cyc(0, 0, 0, e_t3(4, 0), "mul_t3");
    cyc(0, 0, 0, e_t4(A_MUL, 5, 0), "mul_t4");
    cyc(0, 0, 0, e_t5lo(0), "mul_t5");
    cyc(0, 0, 0, e_t6(0), "mul_t6");
    cyc(0, 0, 0, e_t0(0), "mul_back_t0");

    // NOT R2 = ~R7
    IRVal = mk_ir(5'b10001, 4'd2, 4'd7, 4'd0);
    cyc(0, 0, 0, e_t1(0), "not_t1");
    cyc(0, 0, 0, e_t2(0), "not_t2");
    cyc(0, 0, 0, e_idle(0), "not_t3");
    cyc(0, 0, 0, e_t4(A_NOT, 7, 0), "not_t4");
    cyc(0, 0, 0, e_t5wb(2, 0), "not_t5");
    cyc(0, 0, 0, e_t0(0), "not_back_t0");

    // OR R15 = R0 | R9 with three wait cycles in T1
    IRVal = mk_ir(5'b01010, 4'd15, 4'd0, 4'd9);
    cyc(0, 0, 0, e_t1(0), "wait_t1a");
    cyc(0, 0, 1, e_t1(0), "wait_t1b");
    cyc(0, 0, 1, e_t1(0), "wait_t1c");
    cyc(0, 0, 1, e_t1(0), "wait_t1d");
    cyc(0, 0, 0, e_t2(0), "wait_t2");
    cyc(0, 0, 0, e_t3(0, 0), "wait_t3");
    cyc(0, 0, 0, e_t4(A_OR, 9, 0), "wait_t4");
    cyc(0, 0, 0, e_t5wb(15, 0), "wait_t5");
    cyc(0, 0, 0, e_t0(0), "wait_back_t0");

    // Undefined opcode 11111
    IRVal = mk_ir(5'b11111, 4'd1, 4'd2, 4'd3);
    cyc(0, 0, 0, e_t1(0), "ill_t1");
    cyc(0, 0, 0, e_t2(0), "ill_t2");
    cyc(0, 0, 0, e_idle(0), "ill_t3");
    cyc(0, 0, 0, e_halt(1), "ill_halt");
    cyc(0, 0, 0, e_halt(1), "ill_halt_hold");
    cyc(0, 1, 0, e_t0(1), "ill_run_t0");

    // HALT opcode keeps the sticky flag
    IRVal = mk_ir(5'b11011, 4'd0, 4'd0, 4'd0);
    cyc(0, 0, 0, e_t1(1), "halt_t1");
    cyc(0, 0, 0, e_t2(1), "halt_t2");
    cyc(0, 0, 0, e_idle(1), "halt_t3");
    cyc(0, 0, 0, e_halt(1), "halt_state");
    cyc(1, 0, 0, e_idle(0), "reset_clears_illegal");

    // SUB R6 = R1 - R2 interrupted by reset in T4
    IRVal = mk_ir(5'b00100, 4'd6, 4'd1, 4'd2);
    cyc(0, 1, 0, e_t0(0), "sub_t0");
    cyc(0, 0, 0, e_t1(0), "sub_t1");
    cyc(0, 0, 0, e_t2(0), "sub_t2");
    cyc(0, 0, 0, e_t3(1, 0), "sub_t3");
    cyc(0, 0, 0, e_t4(A_SUB, 2, 0), "sub_t4");
    cyc(1, 0, 0, e_idle(0), "sub_reset");
    cyc(0, 0, 0, e_idle(0), "sub_post_reset");

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain: observed %0d left expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/datapath_sequencer.md
Name: datapath_sequencer

Overview:
- Moore control FSM that drives the single-bus datapath through fetch (T0–T2) and execute (T3–T6) for register-register ALU instructions.
- Decodes IRVal and produces every datapath strobe: register enables, bus-drive selects, ALU op one-hots, Read, IncPC, and the one-hot GPRin/GPRout vectors.
- Sits beside the datapath; the datapath instance is unchanged.

Parameters:
- BITS, 32, datapath/instruction width.
- REGISTERS, 16, number of GPRs; width of GPRin/GPRout.
- RIDX, 4, GPR index field width; REGISTERS <= 2**RIDX.

Ports:
- Clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high; one clock, one reset.
- run  in  1  leave IDLE/HALT and start fetching.
- mem_wait  in  1  memory not ready; holds T1.
- IRVal  in  BITS  current IR contents.
- PCout, MDRout, Zlowout, Zhighout, LOout, HIout  out  1 each  bus drivers.
- PCin, IRin, RYin, RZin, MARin, MDRin, HIin, LOin  out  1 each  register loads.
- Read, IncPC  out  1 each  memory read, PC increment.
- ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, AND, OR, NEGATE, NOT  out  1 each  ALU op one-hot.
- GPRin, GPRout  out  REGISTERS  one-hot register load / drive.
- instr_done  out  1  one-cycle pulse on the final execute step.
- halted  out  1  high in HALT.
- illegal  out  1  sticky; set on an undefined opcode, cleared by reset.

Behaviour:
- IR format: op=IRVal[31:27], Ra=[26:23], Rb=[22:19], Rc=[18:15].
- Opcodes: ADD 00011, SUB 00100, SHR 00101, SHL 00110, ROR 00111, ROL 01000, AND 01001, OR 01010, MUL 01110, DIV 01111, NEG 10000, NOT 10001, HALT 11011. All others are illegal.
- States: IDLE, T0, T1, T2, T3, T4, T5, T6, HALT. State is registered; outputs decode from state + IRVal only (pure Moore).
- Reset: state=IDLE, illegal=0. In IDLE every strobe, GPRin, GPRout, instr_done and halted are 0.
- IDLE: run=1 -> T0; otherwise stay.
- T0: PCout, MARin, IncPC, RZin -> T1.
- T1: Zlowout, PCin, Read, MDRin.
  - mem_wait=1 holds T1 with the same outputs; PCin re-asserts the same value.
  - mem_wait=0 -> T2.
- T2: MDRout, IRin -> T3. IRVal is valid from T3 onward.
- T3: decode.
  - HALT -> HALT state.
  - Illegal -> HALT, set illegal.
  - NEG/NOT -> T4, no strobes in T3.
  - Otherwise GPRout[Rb], RYin -> T4.
- T4:
  - Binary ops: GPRout[Rc], op strobe, RZin.
  - NEG/NOT: GPRout[Rb], op strobe, RZin.
  - -> T5.
- T5:
  - MUL/DIV: Zlowout, LOin -> T6.
  - Others: Zlowout, GPRin[Ra], instr_done -> T0.
- T6 (MUL/DIV only): Zhighout, HIin, instr_done -> T0.
- HALT: halted=1; run=1 -> T0; illegal stays set.
- Invariants:
  - At most one bus driver (any *out or GPRout bit) per cycle.
  - At most one ALU op strobe per cycle.
  - GPRin/GPRout are one-hot or zero.
- Index out of range (index >= REGISTERS): the GPR vector stays all-zero; not an illegal instruction.
- reset wins over run/mem_wait in the same cycle. Reset mid-instruction returns to IDLE next edge; no partial write completes after that edge.
- Instruction latency: 6 cycles, or 7 for MUL/DIV, plus one per mem_wait cycle.

Decomposition:
- Shared package `seq_pkg`: state encoding (4-bit localparams), opcode constants, IR field bit positions.
- One sub-module `reg_onehot_decoder` (RIDX -> REGISTERS one-hot with enable), instantiated twice for GPRin and GPRout.

Test Plan:
- Reset then run=1, IR=ADD Ra=3 Rb=1 Rc=2 (0x19890000):
  - T0 has PCout/MARin/IncPC/RZin.
  - T3 has GPRout=0x0002.
  - T4 has GPRout=0x0004 and ADD.
  - T5 has GPRin=0x0008 and instr_done.
  - Back to T0 on cycle 7.
- MUL Ra=0 Rb=4 Rc=5:
  - T5: LOin + Zlowout.
  - T6: HIin + Zhighout + instr_done.
  - GPRin stays 0 throughout.
- NOT Ra=2 Rb=7: T3 has no strobes; T4 has GPRout=0x0080 and NOT; T5 has GPRin=0x0004.
- mem_wait high for 3 cycles in T1: T1 outputs held 4 cycles; instruction takes 9 cycles total.
- Opcode 11111:
  - At T3 go to HALT; illegal=1, halted=1.
  - run=1 -> T0 with illegal still 1.
- reset asserted during T4 of SUB: IDLE next edge, all outputs 0, no GPRin pulse.
- Every cycle of all scenarios: assert single bus driver and one-hot ALU op.
